clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
- Multi-channel programmable clock-enable generator; successor to the fixed single-output divider.
- Each of NUM_CH channels has a runtime divisor loaded over a valid/ready config port.
- Each channel produces a one-cycle tick strobe and a near-50% square wave, all in the clk_i domain.
- Feeds debouncers, display multiplexing and timers. Changes are glitch-free: applied only at period boundaries. A global sync realigns all channels.

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 32: divisor/counter width.
- RST_DIV, 100000: divisor loaded into every channel at reset (1 kHz from 100 MHz); 0 = disabled.
- CH_W, $clog2(NUM_CH) (min 1): width of channel select.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- cfg_valid_i  in  1  config request.
- cfg_ready_o  out  1  config accept; transfer on valid&ready.
- cfg_ch_i  in  CH_W  target channel.
- cfg_div_i  in  CNT_W  new divisor D (period in clk_i cycles; 0 = disable).
- cfg_err_o  out  1  one-cycle pulse: accepted request had cfg_ch_i >= NUM_CH.
- sync_i  in  1  realign all channels to count 0.
- tick_o  out  NUM_CH  per-channel one-cycle strobe, once per period.
- sq_o  out  NUM_CH  per-channel square wave.

Behaviour:
- Reset: cnt=0, D=RST_DIV, pending flags=0, tick_o=0, sq_o=(RST_DIV>=2), cfg_err_o=0, cfg_ready_o=1 after reset.
- Counting (D>=1): at each edge cnt <= (cnt==D-1) ? 0 : cnt+1. The D-1→0 edge is the "wrap".
- tick_o[c] is registered and high exactly during cycles where cnt==D-1. First tick after reset falls D-1 edges after release.
- sq_o[c] is registered and high while cnt < D>>1. For odd D: high D>>1 cycles, low the rest. D=1: tick_o constantly 1, sq_o constantly 0.
- D=0: cnt held 0; tick_o=0; sq_o=0.
- Config: one pending slot per channel. cfg_ready_o = !pending[cfg_ch_i], combinational on cfg_ch_i. Out-of-range channel: ready=1, accepted, dropped, cfg_err_o pulses the next cycle.
- Apply rule: a pending divisor is applied at the first wrap strictly after the acceptance edge.
  - On apply: cnt=0 with the new D; pending clears that edge.
  - If the current D=0 (no wraps), apply on the edge after acceptance.
  - If acceptance coincides with a wrap edge, apply at the following wrap.
- sync_i high at an edge, for every channel:
  - cnt <= 0; any pending value is applied immediately; pending clears.
  - tick_o <= (D_new==1); sq_o <= (D_new>=2).
  - sync has priority over wrap and over a config accept on the same edge. That accept still completes and becomes pending, applied at a later wrap.
- Output timing: tick_o and sq_o change only on clk_i edges, with no combinational path from inputs.
- Reset mid-operation: immediate return to reset state; pending loads discarded.

Optional Feature:
- Macro CLKDIV_TICK_CNT_EN.
- Defined: adds output tick_cnt_o [NUM_CH*16] with a 16-bit per-channel counter.
  - Increments on each tick_o cycle and wraps at 0xFFFF→0.
  - Cleared by reset only; sync does not clear it.
- Undefined: the port and counters are absent.

Decomposition:
- Package clkdiv_pkg: CNT_W default, RST_DIV default, tick-counter width constant 16.
- Sub-module clkdiv_channel holds one channel: D register, pending register/flag, cnt, tick/sq registers, optional tick counter.
- Top clkdiv_multi: NUM_CH channel instances, config demux, ready mux, err pulse, sync fan-out.

Test Plan:
- Release reset, RST_DIV=4 → each tick_o high at cycles 3,7,11; sq_o high for cnt 0,1 and low for 2,3.
- Load D=5 on ch1 mid-period (cnt=1 of 4) → no change until the next wrap, then period 5 with 2 high/3 low. cfg_ready_o for ch1 low until apply.
- ch2 with D=0 → tick/sq low. Load D=2 → applied next edge, toggling every cycle. Load D=1 → tick_o[2] held high, sq_o[2] low.
- Second cfg_valid to ch1 while pending → ready=0, stalls until apply. Request with cfg_ch_i=NUM_CH → accepted, cfg_err_o pulse, no channel changes.
- sync_i asserted while ch0 cnt=2, with a load pending on ch3 → all cnt=0 next cycle; ch3 uses its new D immediately; a config accept on the same edge becomes pending.
- CLKDIV_TICK_CNT_EN with D=1 for 65537 cycles → tick_cnt_o wraps to 1. Assert rst_i mid-run → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared defaults for the multi-channel clock-enable generator.
// Optional per-channel tick counters are enabled with CLKDIV_TICK_CNT_EN.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned RST_DIV_DEF = 100000;
    localparam int unsigned TICK_CNT_W  = 16;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: divisor, single pending slot, counter, registered tick/square outputs.
// CLKDIV_TICK_CNT_EN adds a free-running 16-bit count of tick cycles.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned RST_DIV = RST_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             sync,
    output logic             pending,
    output logic             tick,
    output logic             sq
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_D  = CNT_W'(RST_DIV);
    localparam logic             RST_SQ = (RST_D >= CNT_W'(2));

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             apply;

    // Outputs are registered from the next-state values so they line up with cnt.
    always_comb begin
        wrap     = (div != '0) && (cnt == div - CNT_W'(1));
        apply    = pending && (sync || wrap || (div == '0));
        div_next = apply ? pend_div : div;
        cnt_next = (sync || wrap || apply || (div == '0)) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div      <= RST_D;
            pend_div <= '0;
            pending  <= 1'b0;
            cnt      <= '0;
            tick     <= 1'b0;
            sq       <= RST_SQ;
        end else begin
            div  <= div_next;
            cnt  <= cnt_next;
            tick <= (div_next != '0) && (cnt_next == div_next - CNT_W'(1));
            sq   <= (cnt_next < (div_next >> 1));
            // Accept only happens with the slot empty, so it never races an apply.
            if (load) begin
                pending  <= 1'b1;
                pend_div <= load_div;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_TICK_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_CNT_W'(tick);
        end
    end
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable generator: config demux, ready mux, error pulse, sync fan-out.
// Define CLKDIV_TICK_CNT_EN to expose per-channel 16-bit tick counters on tick_cnt_o.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned RST_DIV = RST_DIV_DEF,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic              cfg_err_o,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o
`ifdef CLKDIV_TICK_CNT_EN
    ,
    output logic [NUM_CH*TICK_CNT_W-1:0] tick_cnt_o
`endif
);

    logic [NUM_CH-1:0]    pend;
    logic [NUM_CH-1:0]    load;
    logic [2**CH_W-1:0]   pend_pad;
    logic [31:0]          ch_ext;
    logic                 in_range;
    logic                 accept;

    // Unused select codes read as "not pending", so out-of-range requests are always ready.
    always_comb begin
        pend_pad             = '0;
        pend_pad[NUM_CH-1:0] = pend;
    end

    assign cfg_ready_o = !pend_pad[cfg_ch_i];
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign ch_ext      = 32'(cfg_ch_i);
    assign in_range    = (ch_ext < 32'(NUM_CH));

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            load[c] = accept && in_range && (ch_ext == c);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= accept && !in_range;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clkdiv_channel #(
            .CNT_W  (CNT_W),
            .RST_DIV(RST_DIV)
        ) u_ch (
            .clk     (clk_i),
            .rst     (rst_i),
            .load    (load[c]),
            .load_div(cfg_div_i),
            .sync    (sync_i),
            .pending (pend[c]),
            .tick    (tick_o[c]),
            .sq      (sq_o[c])
`ifdef CLKDIV_TICK_CNT_EN
            ,
            .tick_cnt(tick_cnt_o[c*TICK_CNT_W +: TICK_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (5 channels, 16-bit counters, reset divisor 4).
// Tick-counter wrap scenario runs only when CLKDIV_TICK_CNT_EN is defined.
module tb_clkdiv_multi;

    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RST_DIV = 4;
    localparam int unsigned CH_W    = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [CH_W-1:0]   cfg_ch_i = '0;
    logic [CNT_W-1:0]  cfg_div_i = '0;
    logic              cfg_err_o;
    logic              sync_i = 1'b0;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] sq_o;
`ifdef CLKDIV_TICK_CNT_EN
    logic [NUM_CH*16-1:0] tick_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    clkdiv_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .RST_DIV(RST_DIV),
        .CH_W   (CH_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_err_o  (cfg_err_o),
        .sync_i     (sync_i),
        .tick_o     (tick_o),
        .sq_o       (sq_o)
`ifdef CLKDIV_TICK_CNT_EN
        ,
        .tick_cnt_o (tick_cnt_o)
`endif
    );

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i = 1'b0; cfg_valid_i = 1'b0; sync_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
        cyc(); cyc();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] et, es;
        rst_i = 1'b0; cfg_valid_i = 1'b0; sync_i = 1'b0; cfg_ch_i = 3'd1;
        cyc(); #1;
        n_cmp++; if (tick_o !== 5'b00000) begin n_bad++; $display("FAIL rst_tick got %b want 00000", tick_o); end
        n_cmp++; if (sq_o !== 5'b11111) begin n_bad++; $display("FAIL rst_sq got %b want 11111", sq_o); end
        n_cmp++; if (cfg_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", cfg_err_o); end
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", cfg_ready_o); end
        cyc();
        rst_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            et = ((k % 4) == 3) ? 5'b11111 : 5'b00000;
            es = ((k % 4) < 2) ? 5'b11111 : 5'b00000;
            n_cmp++; if (tick_o !== et) begin n_bad++; $display("FAIL d4_tick k=%0d got %b want %b", k, tick_o, et); end
            n_cmp++; if (sq_o !== es) begin n_bad++; $display("FAIL d4_sq k=%0d got %b want %b", k, sq_o, es); end
        end
    endtask

    task automatic test_mid_period_load();
        int c1;
        apply_reset();
        cyc();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd1; cfg_div_i = 16'd5;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_ready_pre got %b want 1", cfg_ready_o); end
        cyc();
        cfg_valid_i = 1'b0;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_ready_pend got %b want 0", cfg_ready_o); end
        n_cmp++; if ({tick_o[1], sq_o[1]} !== 2'b00) begin n_bad++; $display("FAIL mid_cnt2 got %b want 00", {tick_o[1], sq_o[1]}); end
        cyc();
        n_cmp++; if ({tick_o[1], sq_o[1], cfg_ready_o} !== 3'b100) begin n_bad++; $display("FAIL mid_cnt3 got %b want 100", {tick_o[1], sq_o[1], cfg_ready_o}); end
        cyc();
        n_cmp++; if ({tick_o[1], sq_o[1], cfg_ready_o} !== 3'b011) begin n_bad++; $display("FAIL mid_apply got %b want 011", {tick_o[1], sq_o[1], cfg_ready_o}); end
        for (int j = 1; j <= 10; j++) begin
            cyc();
            c1 = j % 5;
            n_cmp++; if (tick_o[1] !== (c1 == 4)) begin n_bad++; $display("FAIL mid_d5_tick j=%0d got %b want %b", j, tick_o[1], (c1 == 4)); end
            n_cmp++; if (sq_o[1] !== (c1 < 2)) begin n_bad++; $display("FAIL mid_d5_sq j=%0d got %b want %b", j, sq_o[1], (c1 < 2)); end
            n_cmp++; if (tick_o[0] !== ((j % 4) == 3)) begin n_bad++; $display("FAIL mid_ch0_tick j=%0d got %b want %b", j, tick_o[0], ((j % 4) == 3)); end
        end
    endtask

    task automatic test_disable();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd2; cfg_div_i = 16'd0;
        cyc();
        cfg_valid_i = 1'b0;
        cyc(); cyc();
        n_cmp++; if (tick_o[2] !== 1'b1) begin n_bad++; $display("FAIL dis_before got %b want 1", tick_o[2]); end
        cyc();
        n_cmp++; if ({tick_o[2], sq_o[2], cfg_ready_o} !== 3'b001) begin n_bad++; $display("FAIL dis_apply got %b want 001", {tick_o[2], sq_o[2], cfg_ready_o}); end
        for (int j = 0; j < 5; j++) begin
            cyc();
            n_cmp++; if ({tick_o[2], sq_o[2]} !== 2'b00) begin n_bad++; $display("FAIL dis_hold j=%0d got %b want 00", j, {tick_o[2], sq_o[2]}); end
        end
        cfg_valid_i = 1'b1; cfg_div_i = 16'd2;
        cyc();
        cfg_valid_i = 1'b0;
        #1;
        n_cmp++; if ({tick_o[2], sq_o[2], cfg_ready_o} !== 3'b000) begin n_bad++; $display("FAIL d2_accept got %b want 000", {tick_o[2], sq_o[2], cfg_ready_o}); end
        cyc();
        n_cmp++; if ({tick_o[2], sq_o[2], cfg_ready_o} !== 3'b011) begin n_bad++; $display("FAIL d2_apply got %b want 011", {tick_o[2], sq_o[2], cfg_ready_o}); end
        for (int j = 1; j <= 6; j++) begin
            cyc();
            n_cmp++; if ({tick_o[2], sq_o[2]} !== (((j % 2) == 1) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL d2_toggle j=%0d got %b want %b", j, {tick_o[2], sq_o[2]}, (((j % 2) == 1) ? 2'b10 : 2'b01));
            end
        end
        cfg_valid_i = 1'b1; cfg_div_i = 16'd1;
        cyc();
        cfg_valid_i = 1'b0;
        n_cmp++; if ({tick_o[2], sq_o[2]} !== 2'b10) begin n_bad++; $display("FAIL d1_accept got %b want 10", {tick_o[2], sq_o[2]}); end
        cyc();
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL d1_ready got %b want 1", cfg_ready_o); end
        for (int j = 0; j < 5; j++) begin
            n_cmp++; if ({tick_o[2], sq_o[2]} !== 2'b10) begin n_bad++; $display("FAIL d1_hold j=%0d got %b want 10", j, {tick_o[2], sq_o[2]}); end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        apply_reset();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd1; cfg_div_i = 16'd5;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready got %b want 1", cfg_ready_o); end
        cyc();
        cfg_div_i = 16'd7;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_stall k=%0d got %b want 0", k, cfg_ready_o); end
            n_cmp++; if (cfg_err_o !== 1'b0) begin n_bad++; $display("FAIL b2b_err k=%0d got %b want 0", k, cfg_err_o); end
            cyc();
        end
        n_cmp++; if ({tick_o[1], sq_o[1], cfg_ready_o} !== 3'b011) begin n_bad++; $display("FAIL b2b_apply5 got %b want 011", {tick_o[1], sq_o[1], cfg_ready_o}); end
        cyc();
        cfg_valid_i = 1'b0;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_second_pend got %b want 0", cfg_ready_o); end
        cyc(); cyc(); cyc();
        n_cmp++; if ({tick_o[1], sq_o[1]} !== 2'b10) begin n_bad++; $display("FAIL b2b_d5_tick got %b want 10", {tick_o[1], sq_o[1]}); end
        cyc();
        n_cmp++; if ({tick_o[1], sq_o[1], cfg_ready_o} !== 3'b011) begin n_bad++; $display("FAIL b2b_apply7 got %b want 011", {tick_o[1], sq_o[1], cfg_ready_o}); end
        for (int j = 1; j <= 7; j++) begin
            cyc();
            c1 = j % 7;
            n_cmp++; if ({tick_o[1], sq_o[1]} !== {(c1 == 6), (c1 < 3)}) begin
                n_bad++; $display("FAIL b2b_d7 j=%0d got %b want %b", j, {tick_o[1], sq_o[1]}, {(c1 == 6), (c1 < 3)});
            end
        end
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd5; cfg_div_i = 16'd9;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL oor_ready got %b want 1", cfg_ready_o); end
        cyc();
        n_cmp++; if (cfg_err_o !== 1'b1) begin n_bad++; $display("FAIL oor_err5 got %b want 1", cfg_err_o); end
        cfg_ch_i = 3'd7;
        cyc();
        cfg_valid_i = 1'b0;
        n_cmp++; if (cfg_err_o !== 1'b1) begin n_bad++; $display("FAIL oor_err7 got %b want 1", cfg_err_o); end
        cyc();
        n_cmp++; if (cfg_err_o !== 1'b0) begin n_bad++; $display("FAIL oor_err_end got %b want 0", cfg_err_o); end
        n_cmp++; if (tick_o[0] !== 1'b1) begin n_bad++; $display("FAIL oor_ch0_tick got %b want 1", tick_o[0]); end
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_ch_i = 3'(c);
            #1;
            n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL oor_nopend ch=%0d got %b want 1", c, cfg_ready_o); end
        end
    endtask

    task automatic test_sync();
        logic et4, es4;
        apply_reset();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd3; cfg_div_i = 16'd3;
        cyc();
        cfg_valid_i = 1'b0;
        cyc();
        n_cmp++; if ({tick_o[0], sq_o[0]} !== 2'b00) begin n_bad++; $display("FAIL sync_pre got %b want 00", {tick_o[0], sq_o[0]}); end
        sync_i = 1'b1; cfg_valid_i = 1'b1; cfg_ch_i = 3'd4; cfg_div_i = 16'd6;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL sync_acc_ready got %b want 1", cfg_ready_o); end
        cyc();
        sync_i = 1'b0; cfg_valid_i = 1'b0;
        n_cmp++; if (tick_o !== 5'b00000) begin n_bad++; $display("FAIL sync_tick got %b want 00000", tick_o); end
        n_cmp++; if (sq_o !== 5'b11111) begin n_bad++; $display("FAIL sync_sq got %b want 11111", sq_o); end
        cfg_ch_i = 3'd3;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b1) begin n_bad++; $display("FAIL sync_ch3_ready got %b want 1", cfg_ready_o); end
        cfg_ch_i = 3'd4;
        #1;
        n_cmp++; if (cfg_ready_o !== 1'b0) begin n_bad++; $display("FAIL sync_ch4_pend got %b want 0", cfg_ready_o); end
        for (int j = 1; j <= 14; j++) begin
            cyc();
            et4 = (j < 4) ? (j == 3) : (((j - 4) % 6) == 5);
            es4 = (j < 4) ? (j < 2) : (((j - 4) % 6) < 3);
            n_cmp++; if (tick_o[0] !== ((j % 4) == 3)) begin n_bad++; $display("FAIL sync_ch0 j=%0d got %b want %b", j, tick_o[0], ((j % 4) == 3)); end
            n_cmp++; if ({tick_o[3], sq_o[3]} !== {((j % 3) == 2), ((j % 3) == 0)}) begin
                n_bad++; $display("FAIL sync_ch3 j=%0d got %b want %b", j, {tick_o[3], sq_o[3]}, {((j % 3) == 2), ((j % 3) == 0)});
            end
            n_cmp++; if ({tick_o[4], sq_o[4]} !== {et4, es4}) begin n_bad++; $display("FAIL sync_ch4 j=%0d got %b want %b", j, {tick_o[4], sq_o[4]}, {et4, es4}); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd1; cfg_div_i = 16'd9;
        cyc();
        cfg_valid_i = 1'b0;
        cyc(); cyc();
        n_cmp++; if ({tick_o, sq_o, cfg_ready_o} !== 11'b11111_00000_0) begin n_bad++; $display("FAIL arst_pre got %b want 11111000000", {tick_o, sq_o, cfg_ready_o}); end
        #2 rst_i = 1'b0;
        #1;
        n_cmp++; if (tick_o !== 5'b00000) begin n_bad++; $display("FAIL arst_tick got %b want 00000", tick_o); end
        n_cmp++; if (sq_o !== 5'b11111) begin n_bad++; $display("FAIL arst_sq got %b want 11111", sq_o); end
        n_cmp++; if ({cfg_ready_o, cfg_err_o} !== 2'b10) begin n_bad++; $display("FAIL arst_cfg got %b want 10", {cfg_ready_o, cfg_err_o}); end
        cyc();
        rst_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_cmp++; if ({tick_o[1], sq_o[1]} !== {((k % 4) == 3), ((k % 4) < 2)}) begin
                n_bad++; $display("FAIL arst_ch1 k=%0d got %b want %b", k, {tick_o[1], sq_o[1]}, {((k % 4) == 3), ((k % 4) < 2)});
            end
        end
    endtask

`ifdef CLKDIV_TICK_CNT_EN
    task automatic test_tick_cnt();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd0; cfg_div_i = 16'd1;
        cyc();
        cfg_valid_i = 1'b0;
        repeat (65539) cyc();
        n_cmp++; if (tick_cnt_o[15:0] !== 16'd1) begin n_bad++; $display("FAIL tcnt_wrap got %0d want 1", tick_cnt_o[15:0]); end
        n_cmp++; if (tick_cnt_o[31:16] !== 16'd16385) begin n_bad++; $display("FAIL tcnt_ch1 got %0d want 16385", tick_cnt_o[31:16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_mid_period_load();
        test_disable();
        test_back_to_back();
        test_sync();
        test_async_reset();
`ifdef CLKDIV_TICK_CNT_EN
        test_tick_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
